// File: rtl/stump_alu_mc_pkg.sv
// Shared Stump ALU definitions: function codes, flag bit positions and the flag packer.
// Used by the multi-cycle ALU top level and its testbench.
package stump_alu_mc_pkg;

   typedef enum logic [2:0] {
      FN_ADD   = 3'b000,
      FN_ADC   = 3'b001,
      FN_SUB   = 3'b010,
      FN_SBC   = 3'b011,
      FN_AND   = 3'b100,
      FN_OR    = 3'b101,
      FN_MUL   = 3'b110,
      FN_PASSB = 3'b111
   } func_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MULB = 1'b1;

   function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                             input logic v, input logic c);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_V] = v;
      f[FLAG_C] = c;
      return f;
   endfunction

endpackage

// File: rtl/stump_alu_mc_if.sv
// Request/response bundle between the execute-stage controller (master) and the ALU (slave).
interface stump_alu_mc_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       func;
   logic [WIDTH-1:0] operand_A;
   logic [WIDTH-1:0] operand_B;
   logic             c_in;
   logic             csh;
   logic             set_flags;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags_out;
   logic             out_valid;

   modport master (
      output in_valid, func, operand_A, operand_B, c_in, csh, set_flags,
      input  in_ready, result, flags_out, out_valid
   );

   modport slave (
      input  in_valid, func, operand_A, operand_B, c_in, csh, set_flags,
      output in_ready, result, flags_out, out_valid
   );
endinterface

// File: rtl/stump_alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle for WIDTH cycles.
// o_done strobes in the last iterating cycle with that cycle's add already folded in; no stall input.
module stump_alu_mul_iter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_prod_lo,
   output logic             o_prod_hi_nz
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_cnt;

   logic [2*WIDTH-1:0] w_addend;
   logic [2*WIDTH-1:0] w_acc_next;
   logic               w_running;

   assign w_running  = (r_cnt != '0);
   assign w_addend   = r_b[0] ? r_a : '0;
   assign w_acc_next = r_acc + w_addend;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_a   <= {{WIDTH{1'b0}}, i_a};
         r_b   <= i_b;
         r_acc <= '0;
         r_cnt <= CW'(WIDTH);
      end else if (w_running) begin
         r_acc <= w_acc_next;
         r_a   <= r_a << 1;
         r_b   <= r_b >> 1;
         r_cnt <= r_cnt - CW'(1);
      end
   end

   // Product is taken from the next-accumulator value so the final add is not lost.
   assign o_done       = (r_cnt == CW'(1));
   assign o_prod_lo    = w_acc_next[WIDTH-1:0];
   assign o_prod_hi_nz = (w_acc_next[2*WIDTH-1:WIDTH] != '0);

endmodule

// File: rtl/stump_alu_mc.sv
// Multi-cycle Stump ALU: registered result/flags, valid/ready request, iterative MUL.
// Latency 1 for ADD..PASSB, WIDTH+1 for MUL; in_ready low while a MUL iterates, requests then ignored.
module stump_alu_mc
   import stump_alu_mc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   stump_alu_mc_if.slave     bus
);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_flags;
   logic             r_out_valid;
   logic             r_mul_set_flags;

   func_e            w_func;
   logic             w_accept;
   logic             w_is_mul;
   logic             w_is_arith;
   logic [WIDTH-1:0] w_b_sel;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_v;
   logic             w_c;
   logic [3:0]       w_flags;

   logic             w_mul_start;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_lo;
   logic             w_mul_hi_nz;
   logic [3:0]       w_mul_flags;

   assign w_func      = func_e'(bus.func);
   assign bus.in_ready = (r_state == ST_IDLE);
   assign w_accept    = bus.in_valid && bus.in_ready;
   assign w_is_mul    = (w_func == FN_MUL);
   assign w_is_arith  = ~bus.func[2];
   assign w_mul_start = w_accept && w_is_mul;

   always_comb begin
      w_b_sel = bus.operand_B;
      w_cin   = 1'b0;
      case (w_func)
         FN_ADC: w_cin = bus.c_in;
         FN_SUB: begin
            w_b_sel = ~bus.operand_B;
            w_cin   = 1'b1;
         end
         FN_SBC: begin
            w_b_sel = ~bus.operand_B;
            w_cin   = bus.c_in;
         end
         default: ;
      endcase
   end

   assign w_sum = {1'b0, bus.operand_A} + {1'b0, w_b_sel} + {{WIDTH{1'b0}}, w_cin};

   always_comb begin
      w_res = w_sum[WIDTH-1:0];
      case (w_func)
         FN_AND:   w_res = bus.operand_A & bus.operand_B;
         FN_OR:    w_res = bus.operand_A | bus.operand_B;
         FN_PASSB: w_res = bus.operand_B;
         default:  ;
      endcase
   end

   // Overflow is judged on the operand pair actually fed to the adder (B or ~B).
   assign w_v = w_is_arith
              && (bus.operand_A[WIDTH-1] == w_b_sel[WIDTH-1])
              && (w_res[WIDTH-1] != bus.operand_A[WIDTH-1]);
   assign w_c = w_is_arith ? w_sum[WIDTH] : bus.csh;

   assign w_flags     = pack_flags(w_res[WIDTH-1], (w_res == '0), w_v, w_c);
   assign w_mul_flags = pack_flags(w_mul_lo[WIDTH-1], (w_mul_lo == '0), w_mul_hi_nz, 1'b0);

   stump_alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk          (clk),
      .rst          (rst),
      .i_start      (w_mul_start),
      .i_a          (bus.operand_A),
      .i_b          (bus.operand_B),
      .o_done       (w_mul_done),
      .o_prod_lo    (w_mul_lo),
      .o_prod_hi_nz (w_mul_hi_nz)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_result        <= '0;
         r_flags         <= 4'b0000;
         r_out_valid     <= 1'b0;
         r_mul_set_flags <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_is_mul) begin
                     r_state         <= ST_MULB;
                     r_mul_set_flags <= bus.set_flags;
                  end else begin
                     r_result    <= w_res;
                     r_out_valid <= 1'b1;
                     if (bus.set_flags) begin
                        r_flags <= w_flags;
                     end
                  end
               end
            end
            ST_MULB: begin
               if (w_mul_done) begin
                  r_state     <= ST_IDLE;
                  r_result    <= w_mul_lo;
                  r_out_valid <= 1'b1;
                  if (r_mul_set_flags) begin
                     r_flags <= w_mul_flags;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.result    = r_result;
   assign bus.flags_out = r_flags;
   assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_stump_alu_mc.sv
// Directed and random checks of stump_alu_mc at WIDTH=16, plus a WIDTH=8 multiply instance.
module tb_stump_alu_mc;
   import stump_alu_mc_pkg::*;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  flg;
      int          lat;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   exp_t sb_q[$];

   stump_alu_mc_if #(.WIDTH(16)) bus16 ();
   stump_alu_mc_if #(.WIDTH(8))  bus8 ();

   stump_alu_mc #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
   stump_alu_mc #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Independent integer reference: returns {N,Z,V,C,result}.
   function automatic logic [19:0] model(input logic [2:0] f, input logic [15:0] a,
                                         input logic [15:0] b, input logic ci, input logic cs);
      int unsigned ua, ub, s, p;
      int          sa, sb, sv;
      logic [15:0] r;
      logic        v, c;
      ua = 32'(a); ub = 32'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      s = 0; sv = 0; p = 0; r = '0; v = 1'b0; c = 1'b0;
      case (f)
         3'd0: begin s = ua + ub;                       sv = sa + sb; end
         3'd1: begin s = ua + ub + 32'(ci);             sv = sa + sb + int'(ci); end
         3'd2: begin s = ua + (32'd65535 - ub) + 32'd1; sv = sa - sb; end
         3'd3: begin s = ua + (32'd65535 - ub) + 32'(ci); sv = sa - sb - 1 + int'(ci); end
         default: ;
      endcase
      if (f <= 3'd3) begin
         r = s[15:0];
         c = s[16];
         v = (sv > 32767) || (sv < -32768);
      end else if (f == 3'd6) begin
         p = ua * ub;
         r = p[15:0];
         v = (p[31:16] != 16'h0);
      end else begin
         r = (f == 3'd4) ? (a & b) : (f == 3'd5) ? (a | b) : b;
         c = cs;
      end
      return {r[15], (r == 16'h0), v, c, r};
   endfunction

   task automatic drive16(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic cs, input logic sf);
      bus16.in_valid  = 1'b1;
      bus16.func      = f;
      bus16.operand_A = a;
      bus16.operand_B = b;
      bus16.c_in      = ci;
      bus16.csh       = cs;
      bus16.set_flags = sf;
   endtask

   task automatic run_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic cs, input logic sf,
                         input logic [15:0] er, input logic [3:0] ef, input string tag);
      int   n;
      exp_t e;
      sb_q.push_back('{er, ef, (f == FN_MUL) ? 17 : 1});
      drive16(f, a, b, ci, cs, sf);
      n = 0;
      while (!bus16.in_ready && n < 60) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      n = 1;
      while (!bus16.out_valid && n < 60) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, " out_valid"}, 32'(bus16.out_valid), 32'd1);
      e = sb_q.pop_front();
      chk({tag, " result"}, 32'(bus16.result), 32'(e.res));
      chk({tag, " flags"}, 32'(bus16.flags_out), 32'(e.flg));
      chk({tag, " latency"}, 32'(n), 32'(e.lat));
      @(posedge clk); #1;
      chk({tag, " pulse"}, 32'(bus16.out_valid), 32'd0);
   endtask

   initial begin
      int          n;
      int          cnt;
      exp_t        e;
      logic [2:0]  rf;
      logic [15:0] ra, rb;
      logic        rci, rcs;
      logic [19:0] m;

      total = 0;
      bad   = 0;
      rst   = 1'b1;
      drive16(FN_ADD, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      bus16.in_valid = 1'b0;
      bus8.in_valid  = 1'b0;
      bus8.func      = FN_ADD;
      bus8.operand_A = 8'h0;
      bus8.operand_B = 8'h0;
      bus8.c_in      = 1'b0;
      bus8.csh       = 1'b0;
      bus8.set_flags = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset result", 32'(bus16.result), 32'h0);
      chk("reset flags", 32'(bus16.flags_out), 32'h0);
      chk("reset out_valid", 32'(bus16.out_valid), 32'h0);
      chk("reset in_ready", 32'(bus16.in_ready), 32'h1);
      chk("reset8 result", 32'(bus8.result), 32'h0);

      run_op(FN_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 4'b1010, "add_ovf");
      run_op(FN_SUB, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0101, "sub_zero");
      run_op(FN_SBC, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'hFFFF, 4'b1000, "sbc_borrow");
      run_op(FN_AND, 16'hF0F0, 16'h0FF0, 1'b0, 1'b1, 1'b1, 16'h00F0, 4'b0001, "and_csh");
      run_op(FN_OR,  16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 16'hFFF0, 4'b0001, "or_noflags");

      // MUL with an ADD request held throughout the busy period
      sb_q.push_back('{16'h1230, 4'b0000, 17});
      sb_q.push_back('{16'h0002, 4'b0000, 1});
      drive16(FN_MUL, 16'h0123, 16'h0010, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive16(FN_ADD, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
      n = 1; cnt = 0;
      while (!bus16.out_valid && n < 60) begin
         if (bus16.in_ready) cnt++;
         @(posedge clk); #1; n++;
      end
      chk("mul_busy ready_seen", 32'(cnt), 32'd0);
      chk("mul_busy out_valid", 32'(bus16.out_valid), 32'd1);
      chk("mul_busy ready_at_done", 32'(bus16.in_ready), 32'd1);
      e = sb_q.pop_front();
      chk("mul_busy result", 32'(bus16.result), 32'(e.res));
      chk("mul_busy flags", 32'(bus16.flags_out), 32'(e.flg));
      chk("mul_busy latency", 32'(n), 32'(e.lat));
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      e = sb_q.pop_front();
      chk("held_add out_valid", 32'(bus16.out_valid), 32'd1);
      chk("held_add result", 32'(bus16.result), 32'(e.res));
      chk("held_add flags", 32'(bus16.flags_out), 32'(e.flg));

      run_op(FN_MUL, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0110, "mul_hi");

      // WIDTH=8 instance
      sb_q.push_back('{16'h0000, 4'b0110, 9});
      bus8.in_valid  = 1'b1;
      bus8.func      = FN_MUL;
      bus8.operand_A = 8'h10;
      bus8.operand_B = 8'h10;
      bus8.set_flags = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      n = 1;
      while (!bus8.out_valid && n < 60) begin
         @(posedge clk); #1; n++;
      end
      e = sb_q.pop_front();
      chk("mul8 out_valid", 32'(bus8.out_valid), 32'd1);
      chk("mul8 result", 32'(bus8.result), 32'(e.res));
      chk("mul8 flags", 32'(bus8.flags_out), 32'(e.flg));
      chk("mul8 latency", 32'(n), 32'(e.lat));

      for (int i = 0; i < 12; i++) begin
         rf  = 3'($urandom_range(0, 7));
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rci = 1'($urandom_range(0, 1));
         rcs = 1'($urandom_range(0, 1));
         m   = model(rf, ra, rb, rci, rcs);
         run_op(rf, ra, rb, rci, rcs, 1'b1, m[15:0], m[19:16], $sformatf("rand%0d_f%0d", i, rf));
      end

      run_op(FN_ADD, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h3333, 4'(m[19:16]), "add_nf");
      run_op(FN_PASSB, 16'h0000, 16'h8001, 1'b0, 1'b1, 1'b1, 16'h8001, 4'b1001, "passb");

      // Reset during MULB, with a request presented on the reset edge
      drive16(FN_MUL, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      cnt = 0;
      repeat (7) begin
         @(posedge clk); #1;
         if (bus16.out_valid) cnt++;
      end
      rst = 1'b1;
      drive16(FN_ADD, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      bus16.in_valid = 1'b0;
      chk("abort out_valid", 32'(bus16.out_valid), 32'd0);
      chk("abort result", 32'(bus16.result), 32'h0);
      chk("abort flags", 32'(bus16.flags_out), 32'h0);
      chk("abort in_ready", 32'(bus16.in_ready), 32'd1);
      repeat (20) begin
         @(posedge clk); #1;
         if (bus16.out_valid) cnt++;
      end
      chk("abort no completion", 32'(cnt), 32'd0);
      run_op(FN_ADD, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1, 16'h0005, 4'b0000, "add_after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stump_alu_mc.md
# stump_alu_mc

Parametrised, multi-cycle successor to the Stump single-cycle ALU. It registers its result and flags, adds a valid/ready input handshake and a per-operation flag-write enable, and adds an iterative unsigned multiply. It sits in the Stump execute stage: the control FSM issues an operation and waits for `out_valid` before writeback. Datapath width is a parameter, and the 16-bit Stump core is the default instance.

## Interface
- `WIDTH`, default 16: operand, result and multiplier width (≥4).
- `clk  in  1`: sole clock; all state updates on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `in_valid  in  1`: operation request; accepted when `in_valid && in_ready`.
- `in_ready  out  1`: block can accept; low only while a MUL is iterating.
- `func  in  3`: 000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 OR, 110 MUL, 111 PASSB.
- `operand_A  in  WIDTH`: first operand.
- `operand_B  in  WIDTH`: second operand.
- `c_in  in  1`: carry-in for ADC/SBC; sampled at accept.
- `csh  in  1`: shifter carry, used as C for AND/OR/PASSB; sampled at accept.
- `set_flags  in  1`: write `flags_out` on completion of this operation; sampled at accept.
- `result  out  WIDTH`: registered result; holds until the next completion.
- `flags_out  out  4`: registered {N,Z,V,C}; changes only on a completion with `set_flags`.
- `out_valid  out  1`: one-cycle pulse on the cycle `result` first shows a new value.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MULB: busy, `in_ready`=0.
- Accept in IDLE, non-MUL func:
  - Compute combinationally; register `result`/flags at that edge.
  - `out_valid`=1 in the next cycle; stay in IDLE.
- Accept in IDLE, MUL:
  - Latch A, B, `set_flags`; clear the accumulator; load count=WIDTH; go to MULB.
- MULB, each cycle:
  - If B[0], add A into the accumulator (2·WIDTH-bit accumulator).
  - Shift A left and B right; decrement count.
  - At count 1→0: register `result` = accumulator[WIDTH-1:0] (including this cycle's add), pulse `out_valid` next cycle, go to IDLE.
- Arithmetic uses a WIDTH+1-bit sum:
  - ADD: A+B+0.
  - ADC: A+B+c_in.
  - SUB: A+~B+1.
  - SBC: A+~B+c_in.
  - C = bit WIDTH of the sum (1 = no borrow for SUB/SBC).
  - V = signed overflow of the addend pair actually summed: (A[msb]==B'[msb]) && (R[msb]!=A[msb]), where B' is B or ~B.
- Logic/PASSB (AND, OR; PASSB returns `operand_B`): V=0, C=`csh`.
- MUL (unsigned): C=0; V=1 iff accumulator[2·WIDTH-1:WIDTH] ≠ 0.
- All ops: N = R[WIDTH-1]; Z = (R==0).
- `in_valid` while `in_ready`=0 is ignored, not queued; the requester must hold it.
- Back-to-back single-cycle ops are legal: one accept per cycle, one `out_valid` per cycle.

## Timing
- Reset values:
  - State IDLE.
  - `result`=0, `flags_out`=4'b0000, `out_valid`=0.
  - `in_ready`=1 in the cycle after reset deasserts.
  - Internal counter and accumulator cleared.
- Latency, from the accept edge to the `out_valid` cycle:
  - Single-cycle ops: 1.
  - MUL: WIDTH+1.
- `in_ready` drops the cycle after a MUL accept and rises in the same cycle `out_valid` pulses. A new op may be accepted in that same cycle.
- `rst` during MULB:
  - Aborts the multiply with no completion and no `out_valid`.
  - Outputs return to their reset values on that edge.
- `rst` has priority over a simultaneous `in_valid`.
- `flags_out` and `result` update on the same edge; when `set_flags`=0 only `result` updates.
- Sum overflow wraps modulo 2^WIDTH; the MUL product is truncated to its low WIDTH bits.

## Structure
- Function codes and flag bit indices (N=3, Z=2, V=1, C=0) live in the shared Stump definitions file, extended with `MUL` and `PASSB`.
- One sub-module: `stump_alu_mul_iter`, the shift-add datapath with counter and done strobe.
- The top level holds the combinational add/logic path, the FSM and the output registers.

## Test plan
- ADD 0x7FFF+0x0001, `set_flags`=1 -> `result`=0x8000, `flags_out`=4'b1010, `out_valid` exactly 1 cycle after accept.
- SUB 0x0005−0x0005, then SBC 0x0000−0x0001 with `c_in`=1 -> results 0x0000 / 0xFFFF; flags 4'b0101 / 4'b1000.
- AND 0xF0F0&0x0FF0 with `csh`=1, then OR with `set_flags`=0 -> `result` 0x00F0 with flags 4'b0001; second op updates `result` only, flags stay 4'b0001.
- MUL 0x0123×0x0010 -> 0x1230, flags 4'b0000, `out_valid` 17 cycles after accept; `in_valid` held during busy is not accepted until `in_ready`.
- MUL 0x0100×0x0100 -> `result` 0x0000, flags 4'b0110. Repeat with WIDTH=8 (0x10×0x10) -> same flags, latency 9.
- Assert `rst` at cycle 8 of a MUL -> no `out_valid`, all outputs 0, `in_ready`=1 next cycle; then ADD 2+3 -> 0x0005.
